// File: rtl/imem_fetch_if.sv
// Instruction-fetch request/response bundle between the fetch unit (master)
// and the instruction-memory responder (slave).
interface imem_fetch_if;
  logic        iReqValid;
  logic        oReqReady;
  logic [31:0] iReqPC;
  logic        oRespValid;
  logic        iRespReady;
  logic [31:0] oRespInstruction;
  logic [31:0] oRespPC;
  logic        oRespError;

  modport master (
    output iReqValid, iReqPC, iRespReady,
    input  oReqReady, oRespValid, oRespInstruction, oRespPC, oRespError
  );

  modport slave (
    input  iReqValid, iReqPC, iRespReady,
    output oReqReady, oRespValid, oRespInstruction, oRespPC, oRespError
  );
endinterface

// File: rtl/imem_fetch_responder.sv
// Instruction-fetch responder: fixed-latency store read feeding an in-order skid FIFO.
// Optional store parity (with a test inject hook) is enabled by defining IMEM_PARITY_EN.
module imem_fetch_responder #(
  parameter int DEPTH      = 1024,
  parameter int ADDR_W     = 10,
  parameter int LATENCY    = 2,
  parameter int RESP_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  imem_fetch_if.slave       fetch,
  input  logic              iFlush,
  input  logic              iWrEn,
  input  logic [ADDR_W-1:0] iWrAddr,
  input  logic [31:0]       iWrData
`ifdef IMEM_PARITY_EN
  ,
  input  logic              iParityInject
`endif
);

  localparam int NSTG = (LATENCY > 1) ? LATENCY - 1 : 1;
  localparam int PW   = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CW   = $clog2(RESP_DEPTH + 1);

  typedef struct packed {
    logic        valid;
    logic        addr_err;
    logic [31:0] pc;
    logic [31:0] instr;
`ifdef IMEM_PARITY_EN
    logic        par;
`endif
  } entry_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        err;
  } resp_t;

  logic [31:0] mem [DEPTH];
`ifdef IMEM_PARITY_EN
  logic        mem_par [DEPTH];
`endif

  entry_t          stage_q [NSTG];
  entry_t          stage_d [NSTG];
  resp_t           fifo_mem [RESP_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;

  entry_t          entry_in;
  entry_t          fin;
  resp_t           fin_resp;
  logic            req_fire;
  logic            push;
  logic            pop;
  logic [ADDR_W-1:0] rd_idx;
  resp_t           head;

  // Ready comes only from registered state and the flush input, never from the pop.
  assign fetch.oReqReady = !iFlush && (outstanding_q < CW'(RESP_DEPTH));
  assign fetch.oRespValid = (count_q != '0);
  assign head = fifo_mem[rd_ptr_q];
  assign fetch.oRespInstruction = fetch.oRespValid ? head.instr : 32'h0;
  assign fetch.oRespPC          = fetch.oRespValid ? head.pc    : 32'h0;
  assign fetch.oRespError       = fetch.oRespValid ? head.err   : 1'b0;

  // NOTE: every signal written here gets a default first so no path leaves it unassigned, which would infer a latch.
  always_comb begin
    req_fire = fetch.iReqValid && fetch.oReqReady;
    rd_idx   = fetch.iReqPC[ADDR_W+1:2];

    // The store is read before this edge's write lands, giving read-before-write.
    entry_in          = '0;
    entry_in.valid    = req_fire;
    entry_in.pc       = fetch.iReqPC;
    entry_in.addr_err = (fetch.iReqPC[1:0] != 2'b00) || (fetch.iReqPC[31:ADDR_W+2] != '0);
    entry_in.instr    = mem[rd_idx];
`ifdef IMEM_PARITY_EN
    entry_in.par      = mem_par[rd_idx];
`endif

    stage_d    = stage_q;
    stage_d[0] = entry_in;
    for (int i = 1; i < NSTG; i++) begin
      stage_d[i] = stage_q[i-1];
    end
    if (iFlush) begin
      for (int i = 0; i < NSTG; i++) begin
        stage_d[i].valid = 1'b0;
      end
    end

    // With LATENCY==1 the entry goes straight from the store into the FIFO.
    fin = (LATENCY == 1) ? entry_in : stage_q[NSTG-1];
    fin_resp.pc    = fin.pc;
    fin_resp.instr = fin.addr_err ? 32'h0 : fin.instr;
    fin_resp.err   = fin.addr_err;
`ifdef IMEM_PARITY_EN
    if (!fin.addr_err && ((^fin.instr) != fin.par)) begin
      fin_resp.err = 1'b1;
    end
`endif

    push = fin.valid && !iFlush;
    pop  = fetch.oRespValid && fetch.iRespReady && !iFlush;

    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    outstanding_d = outstanding_q;
    if (iFlush) begin
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      count_d       = '0;
      outstanding_d = '0;
    end else begin
      if (push) begin
        wr_ptr_d = (wr_ptr_q == PW'(RESP_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = (rd_ptr_q == PW'(RESP_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
      end
      count_d       = count_q + CW'(push) - CW'(pop);
      outstanding_d = outstanding_q + CW'(req_fire) - CW'(pop);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NSTG; i++) begin
        stage_q[i] <= '0;
      end
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
    end else begin
      stage_q       <= stage_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
    end
  end

  // NOTE: storage arrays carry no reset; valids and counters gate every use of their contents.
  always_ff @(posedge clk) begin
    if (iWrEn) begin
      mem[iWrAddr] <= iWrData;
`ifdef IMEM_PARITY_EN
      mem_par[iWrAddr] <= (^iWrData) ^ iParityInject;
`endif
    end
    if (push) begin
      fifo_mem[wr_ptr_q] <= fin_resp;
    end
  end

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Directed bench for imem_fetch_responder at default parameters (LATENCY=2, RESP_DEPTH=4).
module tb_imem_fetch_responder;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [31:0] wr_data;
`ifdef IMEM_PARITY_EN
  logic        parity_inject;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] words [16];

  imem_fetch_if bus ();

  imem_fetch_responder #(
    .DEPTH(1024), .ADDR_W(10), .LATENCY(2), .RESP_DEPTH(4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .fetch   (bus.slave),
    .iFlush  (flush),
    .iWrEn   (wr_en),
    .iWrAddr (wr_addr),
    .iWrData (wr_data)
`ifdef IMEM_PARITY_EN
    ,
    .iParityInject (parity_inject)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    wr_en = 1'b0;
    wr_addr = '0;
    wr_data = '0;
`ifdef IMEM_PARITY_EN
    parity_inject = 1'b0;
`endif
    bus.iReqValid  = 1'b0;
    bus.iReqPC     = '0;
    bus.iRespReady = 1'b0;

    for (int i = 0; i < 16; i++) words[i] = 32'h1000_0000 | i;
    words[3] = 32'h1111_1111;
    words[5] = 32'h8C22_0004;
    words[8] = 32'hA0A0_0008;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {31'b0, bus.oRespValid}, 32'h0);
    check("rst_instr", bus.oRespInstruction, 32'h0);
    check("rst_pc", bus.oRespPC, 32'h0);
    check("rst_err", {31'b0, bus.oRespError}, 32'h0);
    reset = 1'b0;
    #1;
    check("rst_ready", {31'b0, bus.oReqReady}, 32'h1);

    // Load store words 0..15
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1;
      wr_addr = 10'(i);
      wr_data = words[i];
      tick();
    end
    wr_en = 1'b0;

    // 1: single fetch, latency 2
    bus.iRespReady = 1'b1;
    bus.iReqValid = 1'b1;
    bus.iReqPC = 32'h14;
    #1;
    check("t1_ready", {31'b0, bus.oReqReady}, 32'h1);
    tick();
    bus.iReqValid = 1'b0;
    check("t1_valid_early", {31'b0, bus.oRespValid}, 32'h0);
    tick();
    check("t1_valid", {31'b0, bus.oRespValid}, 32'h1);
    check("t1_instr", bus.oRespInstruction, 32'h8C22_0004);
    check("t1_pc", bus.oRespPC, 32'h14);
    check("t1_err", {31'b0, bus.oRespError}, 32'h0);
    tick();
    check("t1_drained", {31'b0, bus.oRespValid}, 32'h0);

    // 2: fill credits with iRespReady low, then drain in order
    bus.iRespReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.iReqValid = 1'b1;
      bus.iReqPC = 32'(4 * i);
      #1;
      check($sformatf("t2_ready_%0d", i), {31'b0, bus.oReqReady}, 32'h1);
      tick();
    end
    bus.iReqPC = 32'h10;
    #1;
    check("t2_full", {31'b0, bus.oReqReady}, 32'h0);
    tick();
    bus.iReqValid = 1'b0;
    check("t2_head_pc", bus.oRespPC, 32'h0);
    tick();
    check("t2_hold_pc", bus.oRespPC, 32'h0);
    check("t2_hold_instr", bus.oRespInstruction, words[0]);
    check("t2_still_full", {31'b0, bus.oReqReady}, 32'h0);
    bus.iRespReady = 1'b1;
    #1;
    check("t2_full_at_pop", {31'b0, bus.oReqReady}, 32'h0);
    tick();
    check("t2_ready_after_pop", {31'b0, bus.oReqReady}, 32'h1);
    for (int k = 1; k < 4; k++) begin
      check($sformatf("t2_valid_%0d", k), {31'b0, bus.oRespValid}, 32'h1);
      check($sformatf("t2_pc_%0d", k), bus.oRespPC, 32'(4 * k));
      check($sformatf("t2_instr_%0d", k), bus.oRespInstruction, words[k]);
      tick();
    end
    check("t2_drained", {31'b0, bus.oRespValid}, 32'h0);

    // 3: misaligned and out-of-range PCs
    bus.iReqValid = 1'b1;
    bus.iReqPC = 32'h2;
    tick();
    bus.iReqPC = 32'h1000;
    tick();
    bus.iReqValid = 1'b0;
    check("t3_valid_a", {31'b0, bus.oRespValid}, 32'h1);
    check("t3_pc_a", bus.oRespPC, 32'h2);
    check("t3_instr_a", bus.oRespInstruction, 32'h0);
    check("t3_err_a", {31'b0, bus.oRespError}, 32'h1);
    tick();
    check("t3_valid_b", {31'b0, bus.oRespValid}, 32'h1);
    check("t3_pc_b", bus.oRespPC, 32'h1000);
    check("t3_instr_b", bus.oRespInstruction, 32'h0);
    check("t3_err_b", {31'b0, bus.oRespError}, 32'h1);
    tick();
    check("t3_drained", {31'b0, bus.oRespValid}, 32'h0);

    // 4: flush with work in the pipeline and FIFO
    bus.iRespReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.iReqValid = 1'b1;
      bus.iReqPC = 32'(4 * i);
      tick();
    end
    bus.iReqPC = 32'h30;
    bus.iRespReady = 1'b1;
    flush = 1'b1;
    #1;
    check("t4_ready_in_flush", {31'b0, bus.oReqReady}, 32'h0);
    tick();
    flush = 1'b0;
    bus.iReqValid = 1'b0;
    #1;
    check("t4_valid_after", {31'b0, bus.oRespValid}, 32'h0);
    check("t4_ready_after", {31'b0, bus.oReqReady}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("t4_no_stale_%0d", i), {31'b0, bus.oRespValid}, 32'h0);
    end
    bus.iReqValid = 1'b1;
    bus.iReqPC = 32'h20;
    tick();
    bus.iReqValid = 1'b0;
    tick();
    check("t4_new_valid", {31'b0, bus.oRespValid}, 32'h1);
    check("t4_new_pc", bus.oRespPC, 32'h20);
    check("t4_new_instr", bus.oRespInstruction, 32'hA0A0_0008);
    tick();
    check("t4_new_alone", {31'b0, bus.oRespValid}, 32'h0);

    // 5: same-edge write and read of word 3
    wr_en = 1'b1;
    wr_addr = 10'd3;
    wr_data = 32'hDEAD_BEEF;
    bus.iReqValid = 1'b1;
    bus.iReqPC = 32'hC;
    tick();
    wr_en = 1'b0;
    bus.iReqValid = 1'b0;
    tick();
    check("t5_old_data", bus.oRespInstruction, 32'h1111_1111);
    tick();
    bus.iReqValid = 1'b1;
    tick();
    bus.iReqValid = 1'b0;
    tick();
    check("t5_new_data", bus.oRespInstruction, 32'hDEAD_BEEF);
    tick();

    // 6: asynchronous reset mid-burst
    bus.iRespReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.iReqValid = 1'b1;
      bus.iReqPC = 32'(4 * i);
      tick();
    end
    check("t6_busy", {31'b0, bus.oRespValid}, 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check("t6_valid_async", {31'b0, bus.oRespValid}, 32'h0);
    check("t6_pc_async", bus.oRespPC, 32'h0);
    bus.iReqValid = 1'b0;
    tick();
    reset = 1'b0;
    bus.iRespReady = 1'b1;
    #1;
    check("t6_ready_release", {31'b0, bus.oReqReady}, 32'h1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("t6_quiet_%0d", i), {31'b0, bus.oRespValid}, 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
